// File: rtl/seg7_avalon_display.sv
// Avalon-MM seven-segment display controller: per-digit value registers, hex decode,
// decimal-point mask, per-digit blink and PWM brightness; registered segment outputs.
module seg7_avalon_display #(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25000000,
    parameter int PWM_BITS   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [8*NUM_DIGITS-1:0] digits
);
    localparam int                  BW         = $clog2(BLINK_DIV);
    localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;
    localparam logic [7:0]          SEG_BLANK  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [2:0]                   ctrl_q, ctrl_d;
    logic [PWM_BITS-1:0]          bright_q, bright_d;
    logic [NUM_DIGITS-1:0]        dpmask_q, dpmask_d;
    logic [NUM_DIGITS-1:0]        blinkmask_q, blinkmask_d;
    logic [NUM_DIGITS-1:0][7:0]   digit_q, digit_d;
    logic [BW-1:0]                blink_cnt_q, blink_cnt_d;
    logic                         phase_off_q, phase_off_d;
    logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
    logic [8*NUM_DIGITS-1:0]      digits_q, digits_d;
    logic [31:0]                  rdata_q, rdata_d;

    logic [15:0] we;
    logic [31:0] reg_map [16];
    logic        lit;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    // Full 16-entry address decode; addresses with no register read as zero.
    for (genvar g = 0; g < 16; g++) begin : g_addr
        assign we[g] = avs_write && (avs_address == 4'(g));
        if (g == 0) begin : g_ctrl
            assign reg_map[g] = 32'(ctrl_q);
        end else if (g == 1) begin : g_bright
            assign reg_map[g] = 32'(bright_q);
        end else if (g == 2) begin : g_dp
            assign reg_map[g] = 32'(dpmask_q);
        end else if (g == 3) begin : g_bm
            assign reg_map[g] = 32'(blinkmask_q);
        end else if (g < 4 + NUM_DIGITS) begin : g_dig
            assign reg_map[g] = 32'(digit_q[g-4]);
        end else begin : g_none
            assign reg_map[g] = '0;
        end
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        bright_d    = bright_q;
        dpmask_d    = dpmask_q;
        blinkmask_d = blinkmask_q;
        if (we[0]) ctrl_d      = avs_writedata[2:0];
        if (we[1]) bright_d    = avs_writedata[PWM_BITS-1:0];
        if (we[2]) dpmask_d    = avs_writedata[NUM_DIGITS-1:0];
        if (we[3]) blinkmask_d = avs_writedata[NUM_DIGITS-1:0];
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) rdata_d = reg_map[avs_address];
    end

    // A CTRL write with BLINK_EN clear restarts the blink cycle in its on phase.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_off_d = phase_off_q;
        if (we[0] && !avs_writedata[2]) begin
            blink_cnt_d = '0;
            phase_off_d = 1'b0;
        end else if (ctrl_q[2]) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_off_d = !phase_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        lit       = (bright_q == BRIGHT_MAX) || (pwm_cnt_q < bright_q);
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [7:0] pat;
        logic       show;
        assign digit_d[g] = we[g+4] ? avs_writedata[7:0] : digit_q[g];
        assign pat  = ctrl_q[1] ? {dpmask_q[g], hex_glyph(digit_q[g][3:0])} : digit_q[g];
        assign show = ctrl_q[0] && lit && !(ctrl_q[2] && blinkmask_q[g] && phase_off_q);
        assign digits_d[8*g +: 8] = !show ? SEG_BLANK : ((ACTIVE_LOW != 0) ? ~pat : pat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            bright_q    <= '1;
            dpmask_q    <= '0;
            blinkmask_q <= '0;
            digit_q     <= '0;
            blink_cnt_q <= '0;
            phase_off_q <= 1'b0;
            pwm_cnt_q   <= '0;
            digits_q    <= {NUM_DIGITS{SEG_BLANK}};
            rdata_q     <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            bright_q    <= bright_d;
            dpmask_q    <= dpmask_d;
            blinkmask_q <= blinkmask_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            phase_off_q <= phase_off_d;
            pwm_cnt_q   <= pwm_cnt_d;
            digits_q    <= digits_d;
            rdata_q     <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign digits       = digits_q;

endmodule

// File: tb/tb_seg7_avalon_display.sv
// Bench for seg7_avalon_display: cycle-by-cycle reference model, a glyph vector table,
// directed blink/PWM/reset sequences and randomized register traffic.
module tb_seg7_avalon_display;
    localparam int ND = 6;
    localparam int BD = 8;

    logic        clk = 1'b0;
    logic        reset, avs_write, avs_read;
    logic [3:0]  avs_address;
    logic [31:0] avs_writedata, avs_readdata;
    logic [47:0] digits;

    always #5 clk = ~clk;

    seg7_avalon_display #(
        .NUM_DIGITS(ND),
        .BLINK_DIV (BD),
        .PWM_BITS  (4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .digits       (digits)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: register contents plus cycle counts since reset / since blink restart.
    logic [2:0]  m_ctrl;
    logic [3:0]  m_bright;
    logic [5:0]  m_dp, m_bm;
    logic [7:0]  m_dig [ND];
    int          m_cycles, m_ticks;
    logic [47:0] exp_digits;
    logic [31:0] exp_rd;
    bit          m_valid = 1'b0;

    typedef struct {
        logic [2:0] ctrl;
        logic [7:0] dig;
        logic       dp;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [10];

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [47:0] model_digits();
        logic [47:0] r;
        logic [7:0]  p;
        bit          lit, off, show;
        lit = (m_bright == 4'hF) || ((m_cycles % 16) < int'(m_bright));
        off = ((m_ticks / BD) % 2) == 1;
        for (int i = 0; i < ND; i++) begin
            p    = m_ctrl[1] ? {m_dp[i], glyph(m_dig[i][3:0])} : m_dig[i];
            show = m_ctrl[0] && lit && !(m_ctrl[2] && m_bm[i] && off);
            r[8*i +: 8] = show ? ~p : 8'hFF;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        int idx;
        idx = int'(a) - 4;
        case (a)
            4'd0: return {29'd0, m_ctrl};
            4'd1: return {28'd0, m_bright};
            4'd2: return {26'd0, m_dp};
            4'd3: return {26'd0, m_bm};
            default: return (idx >= 0 && idx < ND) ? {24'd0, m_dig[idx]} : 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        int idx;
        if (reset) begin
            m_ctrl = '0; m_bright = 4'hF; m_dp = '0; m_bm = '0;
            for (int i = 0; i < ND; i++) m_dig[i] = '0;
            m_cycles = 0; m_ticks = 0;
            exp_digits = 48'hFFFF_FFFF_FFFF;
            exp_rd = '0;
            m_valid = 1'b1;
        end else begin
            exp_digits = model_digits();
            if (avs_read) exp_rd = model_read(avs_address);
            if (avs_write && avs_address == 4'd0 && !avs_writedata[2]) m_ticks = 0;
            else if (m_ctrl[2]) m_ticks++;
            m_cycles++;
            if (avs_write) begin
                idx = int'(avs_address) - 4;
                case (avs_address)
                    4'd0: m_ctrl   = avs_writedata[2:0];
                    4'd1: m_bright = avs_writedata[3:0];
                    4'd2: m_dp     = avs_writedata[5:0];
                    4'd3: m_bm     = avs_writedata[5:0];
                    default: if (idx >= 0 && idx < ND) m_dig[idx] = avs_writedata[7:0];
                endcase
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [3:0] a, input logic [31:0] d);
        reset = r; avs_write = w; avs_read = rd; avs_address = a; avs_writedata = d;
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            check("model_digits", {16'd0, digits}, {16'd0, exp_digits});
            check("model_readdata", {32'd0, avs_readdata}, {32'd0, exp_rd});
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b0, 1'b1, a, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        int cnt, run, maxrun, bad, nmid, k;
        bit found, stopped;
        bit on1 [48];
        int runs [$];

        vecs[0] = '{3'b011, 8'h00, 1'b0, 8'hC0};
        vecs[1] = '{3'b011, 8'h01, 1'b0, 8'hF9};
        vecs[2] = '{3'b011, 8'h02, 1'b1, 8'h24};
        vecs[3] = '{3'b011, 8'h05, 1'b0, 8'h92};
        vecs[4] = '{3'b011, 8'h0B, 1'b0, 8'h83};
        vecs[5] = '{3'b011, 8'hFD, 1'b0, 8'hA1};
        vecs[6] = '{3'b011, 8'h0E, 1'b1, 8'h06};
        vecs[7] = '{3'b011, 8'h0F, 1'b0, 8'h8E};
        vecs[8] = '{3'b001, 8'h5A, 1'b1, 8'hA5};
        vecs[9] = '{3'b000, 8'h5A, 1'b0, 8'hFF};

        reset = 1'b1; avs_write = 1'b0; avs_read = 1'b0; avs_address = '0; avs_writedata = '0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0);

        // Reset state
        check("reset_digits", {16'd0, digits}, 64'h0000_FFFF_FFFF_FFFF);
        for (int a = 0; a < 10; a++) begin
            rd(4'(a));
            check("reset_reg", {32'd0, avs_readdata}, (a == 1) ? 64'hF : 64'h0);
        end

        // Hex mode with DP
        wr(4'd4, 32'h3); wr(4'd9, 32'hA); wr(4'd0, 32'h3); wr(4'd2, 32'h1);
        idle(); idle();
        check("hex_dig0", {56'd0, digits[7:0]}, 64'h30);
        check("hex_dig5", {56'd0, digits[47:40]}, 64'h88);
        check("hex_dig1", {56'd0, digits[15:8]}, 64'hC0);

        // Raw mode ignores DPMASK
        wr(4'd0, 32'h1); wr(4'd6, 32'h7F);
        idle(); idle();
        check("raw_dig2", {56'd0, digits[23:16]}, 64'h80);
        check("raw_dig0_nodp", {56'd0, digits[7:0]}, 64'hFC);

        // PWM at BRIGHT=4
        wr(4'd1, 32'h4); idle();
        cnt = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 64; i++) begin
            idle();
            if (digits[23:16] == 8'h80) begin
                cnt++; run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
        end
        check("pwm_on_count", 64'(cnt), 64'd16);
        check("pwm_max_run", 64'(maxrun), 64'd4);
        wr(4'd1, 32'h0); idle();
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            idle();
            if (digits != 48'hFFFF_FFFF_FFFF) bad++;
        end
        check("bright0_dark", 64'(bad), 64'd0);

        // Blink digit1, 8 on / 8 off
        wr(4'd1, 32'hF); wr(4'd5, 32'h8); wr(4'd3, 32'h2); wr(4'd0, 32'h7);
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            idle();
            on1[i] = (digits[15:8] == 8'h80);
            if (digits[7:0] != 8'h30) bad++;
        end
        check("blink_others_on", 64'(bad), 64'd0);
        runs.delete(); run = 1;
        for (int i = 1; i < 48; i++) begin
            if (on1[i] == on1[i-1]) run++;
            else begin runs.push_back(run); run = 1; end
        end
        runs.push_back(run);
        bad = 0; nmid = 0;
        for (int i = 1; i < runs.size() - 1; i++) begin
            nmid++;
            if (runs[i] != 8) bad++;
        end
        check("blink_run_len", 64'(bad), 64'd0);
        check("blink_run_count", 64'(nmid >= 3), 64'd1);

        // Clearing BLINK_EN mid-off-phase
        found = 1'b0;
        for (k = 0; k < 20 && !found; k++) begin idle(); found = (digits[15:8] == 8'h80); end
        check("blink_wait_on", 64'(found), 64'd1);
        found = 1'b0;
        for (k = 0; k < 20 && !found; k++) begin idle(); found = (digits[15:8] == 8'hFF); end
        check("blink_wait_off", 64'(found), 64'd1);
        idle(); idle();
        check("blink_still_off", {56'd0, digits[15:8]}, 64'hFF);
        wr(4'd0, 32'h3); idle();
        check("blink_disable_on", {56'd0, digits[15:8]}, 64'h80);

        // Unmapped addresses
        rd(4'd15);
        check("rd_unmapped", {32'd0, avs_readdata}, 64'h0);
        wr(4'd12, 32'hFFFF_FFFF);
        rd(4'd4);
        check("wr12_dig0", {32'd0, avs_readdata}, 64'h3);
        rd(4'd9);
        check("wr12_dig5", {32'd0, avs_readdata}, 64'hA);
        rd(4'd0);
        check("wr12_ctrl", {32'd0, avs_readdata}, 64'h3);

        // Reset while blinking, write during reset discarded
        wr(4'd0, 32'h7);
        repeat (5) idle();
        step(1'b1, 1'b1, 1'b0, 4'd0, 32'h7);
        check("reset_blank", {16'd0, digits}, 64'h0000_FFFF_FFFF_FFFF);
        rd(4'd0);
        check("reset_wr_discard", {32'd0, avs_readdata}, 64'h0);
        wr(4'd5, 32'h8); wr(4'd3, 32'h2); wr(4'd0, 32'h7);
        cnt = 0; stopped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            idle();
            if (!stopped && digits[15:8] == 8'h80) cnt++;
            else stopped = 1'b1;
        end
        check("blink_restart_on", 64'(cnt), 64'd8);

        // Glyph / mode vector table on digit 0
        wr(4'd3, 32'h0); wr(4'd1, 32'hF);
        for (int i = 0; i < 10; i++) begin
            wr(4'd2, {31'd0, vecs[i].dp});
            wr(4'd4, {24'd0, vecs[i].dig});
            wr(4'd0, {29'd0, vecs[i].ctrl});
            idle();
            check("vec_dig0", {56'd0, digits[7:0]}, {56'd0, vecs[i].exp});
        end

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] a;
            a = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, a, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
